// File: rtl/rr_arbiter_16.sv
// ============================================================================
// rr_arbiter_16 : 16-way round-robin arbiter, owner holds until done.
// Optional forced release enabled by defining ARB_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_16 #(
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  grant_id,
  output logic        grant_valid,
  output logic        timeout
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  ptr_q;
  logic [3:0]  grant_id_q;
  logic        grant_valid_q;
  logic [3:0]  ptr_d;
  logic [3:0]  pick_id;
  logic        pick_vld;

  if (TIMEOUT_CYC == 8'd0) begin : g_cfg_check
    $error("TIMEOUT_CYC must be in 1..255");
  end

  // First requester found scanning upward from ptr_q with wraparound.
  always_comb begin
    logic [3:0] idx;
    pick_id  = ptr_q;
    pick_vld = 1'b0;
    idx      = ptr_q;
    for (int k = 0; k < 16; k++) begin
      idx = ptr_q + 4'(k);
      if (!pick_vld && req[idx]) begin
        pick_id  = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign ptr_d = grant_id_q + 4'd1;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       timeout_q;
  logic       tmo_hit;

  assign tmo_hit = (cnt_q == (TIMEOUT_CYC - 8'd1));
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      ptr_q         <= 4'd0;
      grant_id_q    <= 4'd0;
      grant_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= 8'd0;
      timeout_q     <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_id_q    <= pick_id;
            grant_valid_q <= 1'b1;
            state_q       <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= 8'd0;
`endif
          end
        end
        S_BUSY: begin
          // done takes priority over a coincident timeout.
          if (done) begin
            grant_valid_q <= 1'b0;
            ptr_q         <= ptr_d;
            state_q       <= S_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            grant_valid_q <= 1'b0;
            ptr_q         <= ptr_d;
            state_q       <= S_IDLE;
            timeout_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign grant       = grant_valid_q ? (16'h0001 << grant_id_q) : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_16.sv
// ============================================================================
// tb_rr_arbiter_16 : directed vector table plus multi-cycle sequences.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbiter_16;

  logic        clk;
  logic        resetn;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter_16 #(.TIMEOUT_CYC(8'd4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic [15:0] req;
    logic        done;
    logic        vld;
    logic [3:0]  id;
    logic [15:0] gnt;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  task automatic add(input logic rn, input logic [15:0] r, input logic d,
                     input logic v, input logic [3:0] id, input logic [15:0] g);
    vecs[nvec] = '{rn, r, d, v, id, g};
    nvec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcnt;
    int bad;
    resetn = 1'b0;
    req    = 16'h0000;
    done   = 1'b0;

    //   rstn  req       done vld id     grant
    add(1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0000); // reset
    add(1'b0, 16'hFFFF, 1'b0, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h0020, 1'b0, 1'b1, 4'd5,  16'h0020); // single requester
    add(1'b1, 16'h0020, 1'b1, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h0060, 1'b0, 1'b1, 4'd6,  16'h0040); // ptr=6
    add(1'b1, 16'h0060, 1'b1, 1'b0, 4'd0,  16'h0000);
    add(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000); // ptr back to 0
    add(1'b1, 16'h8021, 1'b0, 1'b1, 4'd0,  16'h0001); // rotation
    add(1'b1, 16'h8021, 1'b0, 1'b1, 4'd0,  16'h0001);
    add(1'b1, 16'h8021, 1'b1, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h8021, 1'b0, 1'b1, 4'd5,  16'h0020);
    add(1'b1, 16'h8021, 1'b0, 1'b1, 4'd5,  16'h0020);
    add(1'b1, 16'h8021, 1'b1, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h8021, 1'b0, 1'b1, 4'd15, 16'h8000);
    add(1'b1, 16'h8021, 1'b0, 1'b1, 4'd15, 16'h8000);
    add(1'b1, 16'h8021, 1'b1, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h8021, 1'b0, 1'b1, 4'd0,  16'h0001);
    add(1'b1, 16'h8021, 1'b0, 1'b1, 4'd0,  16'h0001);
    add(1'b1, 16'h8021, 1'b1, 1'b0, 4'd0,  16'h0000); // ptr=1
    add(1'b1, 16'h4000, 1'b0, 1'b1, 4'd14, 16'h4000);
    add(1'b1, 16'h4000, 1'b1, 1'b0, 4'd0,  16'h0000); // ptr=15
    add(1'b1, 16'h8001, 1'b0, 1'b1, 4'd15, 16'h8000); // stability and wrap
    add(1'b1, 16'h0001, 1'b0, 1'b1, 4'd15, 16'h8000);
    add(1'b1, 16'h0000, 1'b0, 1'b1, 4'd15, 16'h8000);
    add(1'b1, 16'h0001, 1'b1, 1'b0, 4'd0,  16'h0000); // ptr=0
    add(1'b1, 16'h0001, 1'b0, 1'b1, 4'd0,  16'h0001);
    add(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000); // ptr=1
    add(1'b1, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000); // done in idle ignored
    add(1'b1, 16'h0200, 1'b0, 1'b1, 4'd9,  16'h0200);
    add(1'b0, 16'h0200, 1'b0, 1'b0, 4'd0,  16'h0000); // reset mid-busy
    add(1'b1, 16'h0300, 1'b0, 1'b1, 4'd8,  16'h0100);
    add(1'b0, 16'h0300, 1'b1, 1'b0, 4'd0,  16'h0000); // reset beats done/req
    add(1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000);
    add(1'b1, 16'h0300, 1'b0, 1'b1, 4'd8,  16'h0100);
    add(1'b1, 16'h0300, 1'b1, 1'b0, 4'd0,  16'h0000); // ptr=9
    add(1'b1, 16'h0300, 1'b0, 1'b1, 4'd9,  16'h0200);
    add(1'b1, 16'h0300, 1'b1, 1'b0, 4'd0,  16'h0000); // ptr=10
    add(1'b1, 16'h0300, 1'b0, 1'b1, 4'd8,  16'h0100); // scan wraps past 15
    add(1'b1, 16'h0300, 1'b1, 1'b0, 4'd0,  16'h0000);

    for (int i = 0; i < nvec; i++) begin
      resetn = vecs[i].rstn;
      req    = vecs[i].req;
      done   = vecs[i].done;
      step();
      chk($sformatf("v%0d grant_valid", i), 32'(grant_valid), 32'(vecs[i].vld));
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].gnt));
      chk($sformatf("v%0d timeout", i), 32'(timeout), 32'd0);
      if (vecs[i].vld) chk($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(vecs[i].id));
    end

    resetn = 1'b0; req = 16'h0000; done = 1'b0;
    step();
    resetn = 1'b1;
    req    = 16'h0008;
    step();
    chk("hold first grant", {grant_valid, grant_id, grant}, {1'b1, 4'd3, 16'h0008});

`ifdef ARB_TIMEOUT_EN
    vcnt = 1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!grant_valid) break;
      vcnt++;
    end
    chk("timeout valid cycles", 32'(vcnt), 32'd4);
    chk("timeout pulse", 32'(timeout), 32'd1);
    step();
    chk("timeout pulse width", 32'(timeout), 32'd0);
    chk("regrant after timeout", {grant_valid, grant_id, grant}, {1'b1, 4'd3, 16'h0008});
    step(); step(); step();
    done = 1'b1;
    step();
    chk("done beats timeout valid", 32'(grant_valid), 32'd0);
    chk("done beats timeout flag", 32'(timeout), 32'd0);
    done = 1'b0;
    req  = 16'h0018;
    step();
    chk("ptr after done+timeout", {grant_valid, grant_id}, {1'b1, 4'd4});
    chk("no timeout after done", 32'(timeout), 32'd0);
`else
    bad = 0;
    vcnt = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (!(grant_valid && grant_id == 4'd3 && grant == 16'h0008 && timeout == 1'b0)) bad++;
      else vcnt++;
    end
    chk("hold 120 cycles bad", 32'(bad), 32'd0);
    chk("hold 120 cycles good", 32'(vcnt), 32'd120);
    done = 1'b1;
    step();
    chk("release after long hold", {grant_valid, grant}, {1'b0, 16'h0000});
    done = 1'b0;
    step();
    chk("regrant after long hold", {grant_valid, grant_id, timeout}, {1'b1, 4'd3, 1'b0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Round-robin arbiter sharing one resource among up to 16 requesters, emitting both a 4-bit owner index and its one-hot 16-bit grant vector. It sits between the requesters and the shared bus or port. The owner holds the resource until it signals completion. Ownership is registered and handed over fairly through a rotating priority pointer.

## Interface

Parameters:
- TIMEOUT_CYC, default 255: busy-cycle limit before forced release; 8-bit value, 1..255; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- resetn  in  1  reset, synchronous and active-low.
- req  in  16  request lines; bit i high = requester i wants the resource.
- done  in  1  current owner finished; single-cycle pulse, meaningful only in BUSY.
- grant  out  16  one-hot owner vector, bit grant_id set; all-zero when no owner.
- grant_id  out  4  index of current owner.
- grant_valid  out  1  resource currently owned.
- timeout  out  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

## Operation

- States: IDLE, BUSY.
- Registers: state, ptr[3:0] (highest-priority index), grant_id, grant_valid, busy counter cnt[7:0] (only with ARB_TIMEOUT_EN).
- grant is a pure 4-to-16 decode of grant_id, gated by grant_valid. It is never non-zero while grant_valid=0.
- IDLE with req==0: hold; outputs unchanged-idle.
- IDLE with req!=0:
  - Select the first set bit scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
  - Load grant_id, set grant_valid, go BUSY, clear cnt.
- BUSY: grant_id/grant held stable regardless of req changes, including the owner dropping req.
- BUSY with done=1:
  - Clear grant_valid, go IDLE.
  - ptr <= grant_id+1, wrapping mod 16 (15 -> 0).
- done in IDLE: ignored.
- One-cycle bubble between owners: no back-to-back handover in the done cycle.
- Reset (resetn=0 at an edge, any state, including mid-BUSY): state=IDLE, ptr=0, grant_id=0, grant_valid=0, grant=16'h0000, timeout=0, cnt=0.

## Timing

- req rising in IDLE at edge t -> grant valid after edge t+1 (1-cycle latency).
- done sampled at edge t -> grant_valid=0 after edge t.
- With requests pending, the next grant is valid after edge t+1.
- Fairness: a continuously requesting input waits at most 15 other ownerships.
- done and timeout condition in the same cycle: done wins; timeout stays 0; ptr updates identically.
- Reset asserted in the same cycle as req or done: reset wins.

## Configuration

- ARB_TIMEOUT_EN defined:
  - cnt increments each BUSY cycle without done.
  - When cnt reaches TIMEOUT_CYC-1 and done=0 at an edge, release exactly as for done (ptr <= grant_id+1, go IDLE).
  - timeout=1 for that following cycle only.
  - With TIMEOUT_CYC=N, grant_valid is high for exactly N cycles.
- ARB_TIMEOUT_EN undefined:
  - No counter logic.
  - timeout tied to 0.
  - BUSY held until done, indefinitely.

## Test plan

- Reset: resetn=0, req=16'hFFFF, done=0 for 2 cycles -> grant=16'h0000, grant_valid=0, grant_id=0, timeout=0.
- Single requester: req=16'h0020 -> one cycle later grant=16'h0020, grant_id=5. done pulse -> grant_valid=0 next cycle; a later req=16'h0060 grants id 6 (ptr=6).
- Rotation: req=16'h8021 held, done pulsed 2 cycles after each grant -> owners 0, 5, 15, 0 in order, with one idle cycle between each.
- Stability and wrap: with ptr=15, req=16'h8001 -> grant_id=15. Dropping req to 16'h0001 mid-BUSY leaves grant=16'h8000. After done -> next grant_id=0.
- Reset mid-BUSY: owner 9 granted, resetn=0 one cycle -> grant=0, grant_valid=0. With req=16'h0300 afterwards -> grant_id=8 (ptr reset to 0).
- Timeout:
  - With ARB_TIMEOUT_EN, TIMEOUT_CYC=4, req=16'h0008, done never -> grant_valid high exactly 4 cycles, then timeout pulses 1 cycle and id 3 is re-granted after the bubble.
  - Without the macro -> grant held for 100+ cycles with timeout=0.
